// File: rtl/ex_mem_buf.sv
// ex_mem_buf: 2-entry EX/MEM skid FIFO with branch resolution at push and an R0 write guard.
// While empty, data outputs replay the last head shown; wen/br_taken are forced low.
module ex_mem_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_exm_i,
    output logic        ready_exm_o,
    input  logic [31:0] res_exm_i,
    input  logic        z_exm_i,
    input  logic [4:0]  rd_exm_i,
    input  logic        wen_exm_i,
    input  logic [1:0]  br_type_exm_i,
    input  logic [31:0] br_tgt_exm_i,
    input  logic        flush_exm_i,
    output logic        valid_exm_o,
    input  logic        ready_exm_i,
    output logic [31:0] res_exm_o,
    output logic [4:0]  rd_exm_o,
    output logic        wen_exm_o,
    output logic        br_taken_exm_o,
    output logic [31:0] br_tgt_exm_o
);
    logic [31:0] r_res [2];
    logic [4:0]  r_rd  [2];
    logic        r_wen [2];
    logic        r_bt  [2];
    logic [31:0] r_tgt [2];
    logic        r_wp, r_rp;
    logic [1:0]  r_cnt;
    logic [31:0] r_l_res, r_l_tgt;
    logic [4:0]  r_l_rd;
    logic        w_push, w_pop, w_bt, w_wen;

    assign ready_exm_o = r_cnt < 2'd2;
    assign valid_exm_o = r_cnt != 2'd0;
    assign w_push      = valid_exm_i && ready_exm_o && !flush_exm_i;
    assign w_pop       = valid_exm_o && ready_exm_i && !flush_exm_i;
    assign w_bt        = (br_type_exm_i == 2'b01 && z_exm_i) || (br_type_exm_i == 2'b10 && !z_exm_i);
    assign w_wen       = wen_exm_i && rd_exm_i != 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_res[i] <= 32'd0;
                r_rd[i]  <= 5'd0;
                r_wen[i] <= 1'b0;
                r_bt[i]  <= 1'b0;
                r_tgt[i] <= 32'd0;
            end
        end else if (flush_exm_i) begin
            r_cnt <= 2'd0;
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
        end else begin
            if (w_push) begin
                r_res[r_wp] <= res_exm_i;
                r_rd[r_wp]  <= rd_exm_i;
                r_wen[r_wp] <= w_wen;
                r_bt[r_wp]  <= w_bt;
                r_tgt[r_wp] <= br_tgt_exm_i;
                r_wp        <= ~r_wp;
            end
            if (w_pop)
                r_rp <= ~r_rp;
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

    // Snapshot of the currently shown head, replayed once the FIFO drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_l_res <= 32'd0;
            r_l_rd  <= 5'd0;
            r_l_tgt <= 32'd0;
        end else if (valid_exm_o) begin
            r_l_res <= r_res[r_rp];
            r_l_rd  <= r_rd[r_rp];
            r_l_tgt <= r_tgt[r_rp];
        end
    end

    assign res_exm_o      = valid_exm_o ? r_res[r_rp] : r_l_res;
    assign rd_exm_o       = valid_exm_o ? r_rd[r_rp]  : r_l_rd;
    assign br_tgt_exm_o   = valid_exm_o ? r_tgt[r_rp] : r_l_tgt;
    assign wen_exm_o      = valid_exm_o && r_wen[r_rp];
    assign br_taken_exm_o = valid_exm_o && r_bt[r_rp];
endmodule
